// File: rtl/rob_wb_arbiter.sv
// ROB completion write-port arbiter: one holding buffer per result source,
// round-robin grant into a registered write port, flush discards everything pending.
module rob_wb_arbiter #(
    parameter int NUM_REQ = 5,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 3,
    parameter int SRC_W   = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_W-1:0] req_val,
    input  logic [NUM_REQ*DATA_W-1:0] req_npc,
    input  logic [NUM_REQ-1:0]        req_npc_en,
    output logic                      wr_valid,
    input  logic                      wr_ready,
    output logic [TAG_W-1:0]          wr_tag,
    output logic [DATA_W-1:0]         wr_val,
    output logic [DATA_W-1:0]         wr_npc,
    output logic                      wr_npc_en,
    output logic [SRC_W-1:0]          wr_src
);

    logic [NUM_REQ-1:0] r_buf_valid;
    logic [TAG_W-1:0]   r_buf_tag [NUM_REQ];
    logic [DATA_W-1:0]  r_buf_val [NUM_REQ];
    logic [DATA_W-1:0]  r_buf_npc [NUM_REQ];
    logic [NUM_REQ-1:0] r_buf_npc_en;
    logic [SRC_W-1:0]   r_rr_ptr;

    logic               r_wr_valid;
    logic [TAG_W-1:0]   r_wr_tag;
    logic [DATA_W-1:0]  r_wr_val;
    logic [DATA_W-1:0]  r_wr_npc;
    logic               r_wr_npc_en;
    logic [SRC_W-1:0]   r_wr_src;

    logic               w_port_free;
    logic               w_grant_en;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_gnt_any;
    logic [SRC_W-1:0]   w_gnt_idx;
    logic [SRC_W-1:0]   w_rr_next;
    logic [NUM_REQ-1:0] w_accept;
    logic [TAG_W-1:0]   w_sel_tag;
    logic [DATA_W-1:0]  w_sel_val;
    logic [DATA_W-1:0]  w_sel_npc;
    logic               w_sel_npc_en;

    assign w_port_free = !r_wr_valid || wr_ready;
    assign w_grant_en  = !flush && w_port_free;
    // A granted buffer frees up on the same edge, so it may be refilled immediately.
    assign req_ready   = {NUM_REQ{!flush}} & (~r_buf_valid | w_grant);
    assign w_accept    = req_valid & req_ready;

    // Round-robin: scan positions rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ.
    always_comb begin
        w_grant   = '0;
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        if (w_grant_en) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!w_gnt_any && r_buf_valid[i] &&
                        ((int'(r_rr_ptr) + k == i) || (int'(r_rr_ptr) + k == i + NUM_REQ))) begin
                        w_grant[i] = 1'b1;
                        w_gnt_any  = 1'b1;
                        w_gnt_idx  = SRC_W'(i);
                    end
                end
            end
        end
    end

    always_comb begin
        w_sel_tag    = '0;
        w_sel_val    = '0;
        w_sel_npc    = '0;
        w_sel_npc_en = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_tag    = r_buf_tag[i];
                w_sel_val    = r_buf_val[i];
                w_sel_npc    = r_buf_npc[i];
                w_sel_npc_en = r_buf_npc_en[i];
            end
        end
    end

    assign w_rr_next = (w_gnt_idx == SRC_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_accept[i]) begin
                r_buf_tag[i]    <= req_tag[i*TAG_W +: TAG_W];
                r_buf_val[i]    <= req_val[i*DATA_W +: DATA_W];
                r_buf_npc[i]    <= req_npc[i*DATA_W +: DATA_W];
                r_buf_npc_en[i] <= req_npc_en[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_valid <= '0;
            r_rr_ptr    <= '0;
            r_wr_valid  <= 1'b0;
            r_wr_tag    <= '0;
            r_wr_val    <= '0;
            r_wr_npc    <= '0;
            r_wr_npc_en <= 1'b0;
            r_wr_src    <= '0;
        end else if (flush) begin
            r_buf_valid <= '0;
            r_rr_ptr    <= '0;
            r_wr_valid  <= 1'b0;
        end else begin
            // Refill wins over the grant clear when both hit one buffer.
            r_buf_valid <= (r_buf_valid & ~w_grant) | w_accept;
            if (w_gnt_any) begin
                r_wr_valid  <= 1'b1;
                r_wr_tag    <= w_sel_tag;
                r_wr_val    <= w_sel_val;
                r_wr_npc    <= w_sel_npc;
                r_wr_npc_en <= w_sel_npc_en;
                r_wr_src    <= w_gnt_idx;
                r_rr_ptr    <= w_rr_next;
            end else if (w_port_free) begin
                r_wr_valid  <= 1'b0;
            end
        end
    end

    assign wr_valid  = r_wr_valid;
    assign wr_tag    = r_wr_tag;
    assign wr_val    = r_wr_val;
    assign wr_npc    = r_wr_npc;
    assign wr_npc_en = r_wr_npc_en;
    assign wr_src    = r_wr_src;

endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Bench for rob_wb_arbiter: directed scenarios against fixed expectations plus
// a randomized run against a queue-style reference model of the arbiter.
module tb_rob_wb_arbiter;

    localparam int N  = 5;
    localparam int DW = 32;
    localparam int TW = 3;
    localparam int SW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*TW-1:0] req_tag;
    logic [N*DW-1:0] req_val;
    logic [N*DW-1:0] req_npc;
    logic [N-1:0]    req_npc_en;
    logic            wr_valid;
    logic            wr_ready;
    logic [TW-1:0]   wr_tag;
    logic [DW-1:0]   wr_val;
    logic [DW-1:0]   wr_npc;
    logic            wr_npc_en;
    logic [SW-1:0]   wr_src;

    int n_tests = 0;
    int n_fail  = 0;

    rob_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TAG_W(TW), .SRC_W(SW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
        .req_val(req_val), .req_npc(req_npc), .req_npc_en(req_npc_en),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_tag(wr_tag),
        .wr_val(wr_val), .wr_npc(wr_npc), .wr_npc_en(wr_npc_en), .wr_src(wr_src)
    );

    always #5 clk = ~clk;

    // Reference model: one-deep slot per source, a write-port register, a rotating start index.
    bit            m_bv   [N];
    logic [TW-1:0] m_bt   [N];
    logic [DW-1:0] m_bval [N];
    logic [DW-1:0] m_bnpc [N];
    bit            m_ben  [N];
    bit            m_acc  [N];
    bit            m_wv;
    logic [TW-1:0] m_wt;
    logic [DW-1:0] m_wval;
    logic [DW-1:0] m_wnpc;
    bit            m_wen;
    int            m_wsrc;
    int            m_rr;

    function automatic int m_grant();
        if (flush || (m_wv && !wr_ready)) return -1;
        for (int k = 0; k < N; k++) begin
            if (m_bv[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready_vec();
        logic [N-1:0] r;
        int g;
        g = m_grant();
        for (int i = 0; i < N; i++) r[i] = !flush && (!m_bv[i] || g == i);
        return r;
    endfunction

    task automatic tick();
        int            g;
        logic [N-1:0]  rdy;
        bit            rst_s, flush_s, wrr_s;
        logic [N*TW-1:0] tag_s;
        logic [N*DW-1:0] val_s, npc_s;
        logic [N-1:0]  en_s;
        g = m_grant();
        rdy = m_ready_vec();
        for (int i = 0; i < N; i++) m_acc[i] = req_valid[i] && rdy[i];
        rst_s = rst; flush_s = flush; wrr_s = wr_ready;
        tag_s = req_tag; val_s = req_val; npc_s = req_npc; en_s = req_npc_en;
        @(posedge clk);
        if (rst_s) begin
            for (int i = 0; i < N; i++) begin m_bv[i] = 0; m_acc[i] = 0; end
            m_wv = 0; m_wt = '0; m_wval = '0; m_wnpc = '0; m_wen = 0; m_wsrc = 0; m_rr = 0;
        end else if (flush_s) begin
            for (int i = 0; i < N; i++) m_bv[i] = 0;
            m_wv = 0; m_rr = 0;
        end else begin
            if (g >= 0) begin
                m_wv = 1; m_wt = m_bt[g]; m_wval = m_bval[g]; m_wnpc = m_bnpc[g];
                m_wen = m_ben[g]; m_wsrc = g; m_rr = (g + 1) % N; m_bv[g] = 0;
            end else if (!m_wv || wrr_s) begin
                m_wv = 0;
            end
            for (int i = 0; i < N; i++) begin
                if (m_acc[i]) begin
                    m_bv[i] = 1; m_bt[i] = tag_s[i*TW +: TW]; m_bval[i] = val_s[i*DW +: DW];
                    m_bnpc[i] = npc_s[i*DW +: DW]; m_ben[i] = en_s[i];
                end
            end
        end
        #1;
    endtask

    task automatic set_req(input int i, input logic [TW-1:0] t, input logic [DW-1:0] v,
                           input logic [DW-1:0] np, input logic en);
        req_valid[i]         = 1'b1;
        req_tag[i*TW +: TW]  = t;
        req_val[i*DW +: DW]  = v;
        req_npc[i*DW +: DW]  = np;
        req_npc_en[i]        = en;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; req_valid = '0; wr_ready = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; req_valid = '0; wr_ready = 1'b1;
        req_tag = '0; req_val = '0; req_npc = '0; req_npc_en = '0;
        tick(); tick();
        n_tests++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wr_valid: got %0h want 0", wr_valid); end
        n_tests++; if (wr_tag !== '0) begin n_fail++; $display("FAIL reset_wr_tag: got %0h want 0", wr_tag); end
        n_tests++; if (wr_val !== '0 || wr_npc !== '0) begin n_fail++; $display("FAIL reset_wr_data: got val %0h npc %0h want 0", wr_val, wr_npc); end
        n_tests++; if (wr_npc_en !== 1'b0 || wr_src !== '0) begin n_fail++; $display("FAIL reset_wr_ctl: got en %0h src %0h want 0", wr_npc_en, wr_src); end
        n_tests++; if (req_ready !== 5'h1F) begin n_fail++; $display("FAIL reset_req_ready: got %0h want 1f", req_ready); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        set_req(0, 3'd3, 32'h11, 32'h0, 1'b0);
        #1;
        n_tests++; if (req_ready[0] !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %0h want 1", req_ready[0]); end
        tick();
        req_valid = '0;
        n_tests++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL single_edge1_valid: got %0h want 0", wr_valid); end
        tick();
        n_tests++; if (wr_valid !== 1'b1 || wr_tag !== 3'd3 || wr_val !== 32'h11 || wr_src !== 3'd0 || wr_npc_en !== 1'b0) begin
            n_fail++; $display("FAIL single_edge2: got v%0h tag%0h val%0h src%0h en%0h want v1 tag3 val11 src0 en0", wr_valid, wr_tag, wr_val, wr_src, wr_npc_en);
        end
        tick();
        n_tests++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %0h want 0", wr_valid); end
    endtask

    task automatic test_all_sources();
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, TW'(i), 32'h100 + i, 32'h0, 1'b0);
        tick();
        req_valid = '0;
        for (int k = 0; k < N; k++) begin
            tick();
            n_tests++; if (wr_valid !== 1'b1 || wr_src !== SW'(k) || wr_val !== 32'h100 + k) begin
                n_fail++; $display("FAIL all_src_order[%0d]: got v%0h src%0h val%0h want v1 src%0h val%0h", k, wr_valid, wr_src, wr_val, k, 32'h100 + k);
            end
            n_tests++; if (req_ready[k] !== 1'b1) begin n_fail++; $display("FAIL all_src_ready[%0d]: got 0 want 1", k); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_req(2, 3'd2, 32'h200, 32'h0, 1'b0);
        set_req(4, 3'd4, 32'h400, 32'h0, 1'b0);
        tick();
        req_valid = '0;
        tick();
        n_tests++; if (wr_src !== 3'd2 || wr_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first: got src %0h v%0h want src 2 v1", wr_src, wr_valid); end
        set_req(2, 3'd5, 32'h22, 32'h40, 1'b1);
        tick();
        req_valid = '0;
        n_tests++; if (wr_src !== 3'd4 || wr_tag !== 3'd4 || wr_npc_en !== 1'b0) begin n_fail++; $display("FAIL b2b_mem: got src %0h tag %0h en %0h want src 4 tag 4 en 0", wr_src, wr_tag, wr_npc_en); end
        tick();
        n_tests++; if (wr_src !== 3'd2 || wr_tag !== 3'd5 || wr_npc_en !== 1'b1 || wr_npc !== 32'h40) begin
            n_fail++; $display("FAIL b2b_jump: got src %0h tag %0h en %0h npc %0h want src 2 tag 5 en 1 npc 40", wr_src, wr_tag, wr_npc_en, wr_npc);
        end
    endtask

    task automatic test_stall();
        do_reset();
        set_req(0, 3'd1, 32'hA0, 32'h0, 1'b0);
        set_req(3, 3'd6, 32'hB3, 32'h80, 1'b1);
        tick();
        req_valid = '0;
        tick();
        wr_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_tests++; if (wr_valid !== 1'b1 || wr_src !== 3'd0 || wr_tag !== 3'd1 || wr_val !== 32'hA0) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got v%0h src%0h tag%0h val%0h want v1 src0 tag1 valA0", c, wr_valid, wr_src, wr_tag, wr_val);
            end
            n_tests++; if (req_ready[3] !== 1'b0) begin n_fail++; $display("FAIL stall_ready3[%0d]: got 1 want 0", c); end
        end
        wr_ready = 1'b1;
        #1;
        n_tests++; if (req_ready[3] !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready: got 0 want 1"); end
        tick();
        n_tests++; if (wr_src !== 3'd3 || wr_tag !== 3'd6 || wr_val !== 32'hB3 || wr_npc_en !== 1'b1 || wr_npc !== 32'h80) begin
            n_fail++; $display("FAIL stall_next: got src%0h tag%0h val%0h en%0h npc%0h want src3 tag6 valB3 en1 npc80", wr_src, wr_tag, wr_val, wr_npc_en, wr_npc);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, TW'(i), 32'h300 + i, 32'h0, 1'b0);
        tick();
        req_valid = '0;
        tick();
        n_tests++; if (wr_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre_valid: got 0 want 1"); end
        flush = 1'b1;
        set_req(4, 3'd7, 32'h777, 32'h0, 1'b0);
        set_req(0, 3'd7, 32'h770, 32'h0, 1'b0);
        #1;
        n_tests++; if (req_ready !== 5'h00) begin n_fail++; $display("FAIL flush_ready: got %0h want 0", req_ready); end
        tick();
        flush = 1'b0; req_valid = '0;
        #1;
        n_tests++; if (wr_valid !== 1'b0 || req_ready !== 5'h1F) begin n_fail++; $display("FAIL flush_after: got v%0h rdy%0h want v0 rdy1f", wr_valid, req_ready); end
        tick();
        n_tests++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped: got %0h want 0", wr_valid); end
        set_req(0, 3'd1, 32'h501, 32'h0, 1'b0);
        set_req(4, 3'd2, 32'h504, 32'h0, 1'b0);
        tick();
        req_valid = '0;
        tick();
        n_tests++; if (wr_src !== 3'd0 || wr_val !== 32'h501) begin n_fail++; $display("FAIL flush_rr_zero: got src %0h val %0h want src 0 val 501", wr_src, wr_val); end
    endtask

    task automatic test_rst_mid();
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, TW'(i), 32'h600 + i, 32'h60 + i, 1'b1);
        tick();
        req_valid = '0;
        tick(); tick();
        rst = 1'b1; flush = 1'b1; req_valid = '1;
        tick();
        n_tests++; if (wr_valid !== 1'b0 || wr_tag !== '0 || wr_val !== '0 || wr_npc !== '0 || wr_npc_en !== 1'b0 || wr_src !== '0) begin
            n_fail++; $display("FAIL rst_mid_outputs: got v%0h tag%0h val%0h npc%0h en%0h src%0h want all 0", wr_valid, wr_tag, wr_val, wr_npc, wr_npc_en, wr_src);
        end
        rst = 1'b0; flush = 1'b0; req_valid = '0;
        #1;
        n_tests++; if (req_ready !== 5'h1F) begin n_fail++; $display("FAIL rst_mid_ready: got %0h want 1f", req_ready); end
        set_req(0, 3'd3, 32'h11, 32'h0, 1'b0);
        tick();
        req_valid = '0;
        n_tests++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_edge1: got %0h want 0", wr_valid); end
        tick();
        n_tests++; if (wr_valid !== 1'b1 || wr_tag !== 3'd3 || wr_val !== 32'h11 || wr_src !== 3'd0) begin
            n_fail++; $display("FAIL rst_mid_edge2: got v%0h tag%0h val%0h src%0h want v1 tag3 val11 src0", wr_valid, wr_tag, wr_val, wr_src);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] exp_rdy;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(req_valid[i] && !m_acc[i])) begin
                    req_valid[i]        = ($urandom_range(0, 99) < 40);
                    req_tag[i*TW +: TW] = TW'($urandom);
                    req_val[i*DW +: DW] = $urandom;
                    req_npc[i*DW +: DW] = $urandom;
                    req_npc_en[i]       = 1'($urandom);
                end
            end
            wr_ready = ($urandom_range(0, 99) < 70);
            flush    = ($urandom_range(0, 99) < 3);
            #1;
            exp_rdy = m_ready_vec();
            n_tests++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_ready[%0d]: got %0h want %0h", c, req_ready, exp_rdy); end
            tick();
            n_tests++; if (wr_valid !== m_wv) begin n_fail++; $display("FAIL rand_wr_valid[%0d]: got %0h want %0h", c, wr_valid, m_wv); end
            if (m_wv) begin
                n_tests++; if (wr_tag !== m_wt || wr_val !== m_wval || wr_npc !== m_wnpc || wr_npc_en !== m_wen || wr_src !== SW'(m_wsrc)) begin
                    n_fail++; $display("FAIL rand_wr_data[%0d]: got tag%0h val%0h npc%0h en%0h src%0h want tag%0h val%0h npc%0h en%0h src%0h",
                        c, wr_tag, wr_val, wr_npc, wr_npc_en, wr_src, m_wt, m_wval, m_wnpc, m_wen, m_wsrc);
                end
            end
        end
        flush = 1'b0; req_valid = '0; wr_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N; i++) begin m_bv[i] = 0; m_acc[i] = 0; end
        m_wv = 0; m_rr = 0; m_wsrc = 0;
        test_reset();
        test_single();
        test_all_sources();
        test_back_to_back();
        test_stall();
        test_flush();
        test_rst_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
